// File: rtl/updown_counter_par.sv
// Up/down modulo counter with a runtime bound, synchronous load/clear, and wrap pulses plus sticky flags.
// Latency: count, tc_up/tc_dn and ovf/udf are all registered one edge after their cause.
// Backpressure: none; a new operation is accepted on every edge. Define UPDOWN_COUNTER_SATURATE_EN for saturate mode.
module updown_counter_par #(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        up_down,
    input  logic              en,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  max_val,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              sat_mode,
    input  logic              sticky_clr,
    output logic [WIDTH-1:0]  count,
    output logic              tc_up,
    output logic              tc_dn,
    output logic              ovf,
    output logic              udf
);

    localparam logic [WIDTH:0] ONE_X = 1;

    logic [WIDTH-1:0] r_count;
    logic             r_tc_up;
    logic             r_tc_dn;
    logic             r_ovf;
    logic             r_udf;

    logic [WIDTH:0]   w_max_x;
    logic [WIDTH:0]   w_cnt_x;
    logic [WIDTH:0]   w_step_x;
    logic [WIDTH:0]   w_mod;
    logic [WIDTH:0]   w_up_sum;
    logic [WIDTH:0]   w_up_wrap;
    logic [WIDTH:0]   w_dn_wrap;
    logic [WIDTH-1:0] w_nxt;
    logic             w_tc_up;
    logic             w_tc_dn;
    logic             w_sat;

`ifdef UPDOWN_COUNTER_SATURATE_EN
    assign w_sat = sat_mode;
`else
    logic w_unused_sat;
    assign w_unused_sat = sat_mode;
    assign w_sat        = 1'b0;
`endif

    // One extra bit keeps modulus 2^WIDTH exact when max_val is all ones.
    assign w_max_x   = {1'b0, max_val};
    assign w_cnt_x   = {1'b0, r_count};
    assign w_step_x  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign w_mod     = w_max_x + ONE_X;
    assign w_up_sum  = w_cnt_x + w_step_x;
    assign w_up_wrap = w_up_sum - w_mod;
    assign w_dn_wrap = w_cnt_x + w_mod - w_step_x;

    always_comb begin
        w_nxt   = r_count;
        w_tc_up = 1'b0;
        w_tc_dn = 1'b0;
        if (load) begin
            w_nxt = (load_val > max_val) ? max_val : load_val;
        end else if (up_down == 2'b11) begin
            w_nxt = '0;
        end else if (en && (step != '0)) begin
            if (up_down == 2'b01) begin
                if (w_up_sum <= w_max_x) begin
                    w_nxt = w_up_sum[WIDTH-1:0];
                end else begin
                    w_tc_up = 1'b1;
                    if (w_sat)
                        w_nxt = max_val;
                    else if (w_up_wrap > w_max_x)
                        w_nxt = '0;
                    else
                        w_nxt = w_up_wrap[WIDTH-1:0];
                end
            end else if (up_down == 2'b10) begin
                if (w_step_x <= w_cnt_x) begin
                    w_nxt = r_count - step;
                end else begin
                    // A step larger than count+modulus wraps the extended sum past max_val, landing on max_val.
                    w_tc_dn = 1'b1;
                    if (w_sat)
                        w_nxt = '0;
                    else if (w_dn_wrap > w_max_x)
                        w_nxt = max_val;
                    else
                        w_nxt = w_dn_wrap[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_tc_up <= 1'b0;
            r_tc_dn <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_count <= w_nxt;
            r_tc_up <= w_tc_up;
            r_tc_dn <= w_tc_dn;
            r_ovf   <= w_tc_up | (r_ovf & ~sticky_clr);
            r_udf   <= w_tc_dn | (r_udf & ~sticky_clr);
        end
    end

    assign count = r_count;
    assign tc_up = r_tc_up;
    assign tc_dn = r_tc_dn;
    assign ovf   = r_ovf;
    assign udf   = r_udf;

endmodule

// File: tb/tb_updown_counter_par.sv
// Bench for updown_counter_par: 8-bit and 32-bit instances, directed corner cases then randomized traffic.
// Expected values come from an integer-arithmetic reference model of the counting rules.
module tb_updown_counter_par;

    localparam bit SAT_BUILT =
`ifdef UPDOWN_COUNTER_SATURATE_EN
        1'b1;
`else
        1'b0;
`endif
    localparam longint unsigned EXP_SAT_UP = SAT_BUILT ? 9 : 1;
    localparam longint unsigned EXP_SAT_DN = SAT_BUILT ? 0 : 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic [1:0]  ud8,  ud32;
    logic        en8,  en32;
    logic [3:0]  step8, step32;
    logic [7:0]  max8, ldv8;
    logic [31:0] max32, ldv32;
    logic        ld8, ld32, sat8, sat32, clr8, clr32;
    logic [7:0]  cnt8;
    logic [31:0] cnt32;
    logic        tcu8, tcd8, ovf8, udf8, tcu32, tcd32, ovf32, udf32;

    longint unsigned m_cnt8, m_cnt32;
    logic m_ovf8, m_udf8, m_tcu8, m_tcd8, m_ovf32, m_udf32, m_tcu32, m_tcd32;

    int n_tests = 0;
    int n_fail  = 0;

    updown_counter_par #(.WIDTH(8), .STEP_W(4)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .up_down(ud8), .en(en8), .step(step8),
        .max_val(max8), .load(ld8), .load_val(ldv8), .sat_mode(sat8), .sticky_clr(clr8),
        .count(cnt8), .tc_up(tcu8), .tc_dn(tcd8), .ovf(ovf8), .udf(udf8)
    );

    updown_counter_par #(.WIDTH(32), .STEP_W(4)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .up_down(ud32), .en(en32), .step(step32),
        .max_val(max32), .load(ld32), .load_val(ldv32), .sat_mode(sat32), .sticky_clr(clr32),
        .count(cnt32), .tc_up(tcu32), .tc_dn(tcd32), .ovf(ovf32), .udf(udf32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_next(
        input logic ld, input longint unsigned ldv, input logic [1:0] ud, input logic e,
        input longint unsigned stp, input longint unsigned mx, input logic sat, input logic clr,
        inout longint unsigned cnt, inout logic ov, inout logic un, output logic tu, output logic td);
        longint r;
        logic   use_sat;
        use_sat = SAT_BUILT && sat;
        tu = 1'b0;
        td = 1'b0;
        if (ld) begin
            cnt = (ldv > mx) ? mx : ldv;
        end else if (ud == 2'b11) begin
            cnt = 0;
        end else if (e && stp != 0 && ud == 2'b01) begin
            if (cnt + stp <= mx) begin
                cnt = cnt + stp;
            end else begin
                tu = 1'b1;
                r  = longint'(cnt + stp) - longint'(mx) - 1;
                if (use_sat)              cnt = mx;
                else if (r > longint'(mx)) cnt = 0;
                else                       cnt = $unsigned(r);
            end
        end else if (e && stp != 0 && ud == 2'b10) begin
            if (stp <= cnt) begin
                cnt = cnt - stp;
            end else begin
                td = 1'b1;
                r  = longint'(cnt) + longint'(mx) + 1 - longint'(stp);
                if (use_sat)                        cnt = 0;
                else if (r < 0 || r > longint'(mx)) cnt = mx;
                else                                cnt = $unsigned(r);
            end
        end
        ov = tu | (ov & ~clr);
        un = td | (un & ~clr);
    endfunction

    task automatic cycle(input string tag);
        ref_next(ld8, 64'(ldv8), ud8, en8, 64'(step8), 64'(max8), sat8, clr8,
                 m_cnt8, m_ovf8, m_udf8, m_tcu8, m_tcd8);
        ref_next(ld32, 64'(ldv32), ud32, en32, 64'(step32), 64'(max32), sat32, clr32,
                 m_cnt32, m_ovf32, m_udf32, m_tcu32, m_tcd32);
        @(posedge clk);
        #1;
        check({tag, ".cnt8"},  64'(cnt8),  m_cnt8);
        check({tag, ".tcu8"},  64'(tcu8),  64'(m_tcu8));
        check({tag, ".tcd8"},  64'(tcd8),  64'(m_tcd8));
        check({tag, ".ovf8"},  64'(ovf8),  64'(m_ovf8));
        check({tag, ".udf8"},  64'(udf8),  64'(m_udf8));
        check({tag, ".cnt32"}, 64'(cnt32), m_cnt32);
        check({tag, ".tcu32"}, 64'(tcu32), 64'(m_tcu32));
        check({tag, ".tcd32"}, 64'(tcd32), 64'(m_tcd32));
        check({tag, ".ovf32"}, 64'(ovf32), 64'(m_ovf32));
        check({tag, ".udf32"}, 64'(udf32), 64'(m_udf32));
    endtask

    task automatic model_reset();
        m_cnt8 = 0;  m_ovf8 = 0;  m_udf8 = 0;  m_tcu8 = 0;  m_tcd8 = 0;
        m_cnt32 = 0; m_ovf32 = 0; m_udf32 = 0; m_tcu32 = 0; m_tcd32 = 0;
    endtask

    task automatic idle();
        ld8 = 0;  ud8 = 2'b00;  en8 = 1;  step8 = 0;  sat8 = 0;  clr8 = 0;
        ld32 = 0; ud32 = 2'b00; en32 = 1; step32 = 0; sat32 = 0; clr32 = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        idle();
        max8 = 8'd9; ldv8 = 0; max32 = 32'd1000; ldv32 = 0;
        model_reset();
        #12;
        check("rst.cnt8", 64'(cnt8), 0);
        check("rst.ovf8", 64'(ovf8), 0);
        check("rst.tcu32", 64'(tcu32), 0);
        check("rst.cnt32", 64'(cnt32), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 8-bit up wrap with sticky overflow
        ld8 = 1; ldv8 = 8'd8; max8 = 8'd9;
        cycle("ld8");
        ld8 = 0; ud8 = 2'b01; step8 = 4'd3;
        cycle("upwrap8");
        check("upwrap8.cnt_const", 64'(cnt8), 1);
        check("upwrap8.tcu_const", 64'(tcu8), 1);
        ud8 = 2'b00;
        cycle("hold8");
        check("hold8.ovf_const", 64'(ovf8), 1);
        clr8 = 1;
        cycle("clr8");
        check("clr8.ovf_const", 64'(ovf8), 0);
        clr8 = 0;

        // 8-bit down wrap
        ld8 = 1; ldv8 = 8'd1;
        cycle("ld8b");
        ld8 = 0; ud8 = 2'b10; step8 = 4'd3;
        cycle("dnwrap8");
        check("dnwrap8.cnt_const", 64'(cnt8), 8);
        check("dnwrap8.udf_const", 64'(udf8), 1);
        idle();

        // 32-bit full-range wrap and zero step
        max32 = 32'hFFFF_FFFF; ld32 = 1; ldv32 = 32'hFFFF_FFFE;
        cycle("ld32");
        ld32 = 0; ud32 = 2'b01; step32 = 4'd2;
        cycle("upwrap32");
        check("upwrap32.cnt_const", 64'(cnt32), 0);
        check("upwrap32.tcu_const", 64'(tcu32), 1);
        step32 = 4'd0;
        cycle("step0_32");
        check("step0_32.tcu_const", 64'(tcu32), 0);
        idle();

        // priority: load beats clear, clear, then en=0 holds
        ld8 = 1; ldv8 = 8'd200; max8 = 8'd150; ud8 = 2'b11;
        cycle("prio_ld");
        check("prio_ld.cnt_const", 64'(cnt8), 150);
        ld8 = 0;
        cycle("prio_clr");
        check("prio_clr.cnt_const", 64'(cnt8), 0);
        ld8 = 1; ldv8 = 8'd7; ud8 = 2'b00;
        cycle("prio_ld7");
        ld8 = 0; ud8 = 2'b01; en8 = 0; step8 = 4'd3;
        cycle("prio_en0");
        check("prio_en0.cnt_const", 64'(cnt8), 7);
        idle();

        // asynchronous reset between edges
        max8 = 8'd9; ld8 = 1; ldv8 = 8'd8;
        cycle("rst_ld");
        ld8 = 0; ud8 = 2'b01; step8 = 4'd3;
        cycle("rst_up1");
        step8 = 4'd4;
        cycle("rst_up2");
        check("rst_pre.cnt_const", 64'(cnt8), 5);
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst.cnt8", 64'(cnt8), 0);
        check("arst.ovf8", 64'(ovf8), 0);
        check("arst.cnt32", 64'(cnt32), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cycle("post_rst");

        // saturate mode (wraps when the macro is absent)
        sat8 = 1; max8 = 8'd9; ld8 = 1; ldv8 = 8'd8;
        cycle("sat_ld");
        ld8 = 0; ud8 = 2'b01; step8 = 4'd3;
        cycle("sat_up");
        check("sat_up.cnt_const", 64'(cnt8), EXP_SAT_UP);
        ld8 = 1; ldv8 = 8'd1; ud8 = 2'b00;
        cycle("sat_ld1");
        ld8 = 0; ud8 = 2'b10;
        cycle("sat_dn");
        check("sat_dn.cnt_const", 64'(cnt8), EXP_SAT_DN);
        check("sat_dn.tcd_const", 64'(tcd8), 1);
        idle();

        for (int i = 0; i < 400; i++) begin
            ld8   = ($urandom_range(0, 15) == 0);
            ldv8  = 8'($urandom);
            ud8   = 2'($urandom);
            en8   = ($urandom_range(0, 7) != 0);
            step8 = 4'($urandom);
            sat8  = 1'($urandom);
            clr8  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0)
                max8 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(1, 30));
            ld32   = ($urandom_range(0, 15) == 0);
            ldv32  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
            ud32   = 2'($urandom);
            en32   = ($urandom_range(0, 7) != 0);
            step32 = 4'($urandom);
            sat32  = 1'($urandom);
            clr32  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 2))
                    0:       max32 = 32'hFFFF_FFFF;
                    1:       max32 = 32'($urandom_range(1, 30));
                    default: max32 = $urandom;
                endcase
            end
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
